// File: rtl/box_pixel_gen.sv
// Movable coloured boxes over a background: per-pixel hit test with index priority,
// positions updated once per frame by a small FSM, colours cycled on dcolor edges.
module box_pixel_gen #(
   parameter int          NUM_BOXES = 2,
   parameter int          BOX_W     = 64,
   parameter int          BOX_H     = 48,
   parameter int          STEP      = 4,
   parameter int          H_ACTIVE  = 640,
   parameter int          V_ACTIVE  = 480,
   parameter logic [23:0] BG_COLOR  = 24'h000000
) (
   input  logic        rfr_clk,
   input  logic        reset,
   input  logic        video_on,
   input  logic [11:0] pixel_cnt,
   input  logic [11:0] line_cnt,
   input  logic [1:0]  sel_box,
   input  logic        move_up,
   input  logic        move_down,
   input  logic        move_left,
   input  logic        move_right,
   input  logic        dcolor,
   output logic [7:0]  p_red,
   output logic [7:0]  p_green,
   output logic [7:0]  p_blue
);

   localparam logic [11:0] X_MAX  = 12'(H_ACTIVE - BOX_W);
   localparam logic [11:0] Y_MAX  = 12'(V_ACTIVE - BOX_H);
   localparam logic [11:0] STEP_V = 12'(STEP);

   typedef enum logic [1:0] {IDLE, SAMPLE, APPLY} state_t;

   state_t state_q, state_d;

   // latched move request, bit order {up, down, left, right}
   logic [1:0] lsel_q, lsel_d;
   logic [3:0] lmv_q, lmv_d;

   logic [NUM_BOXES-1:0][11:0] x_q, x_d;
   logic [NUM_BOXES-1:0][11:0] y_q, y_d;
   logic [NUM_BOXES-1:0][2:0]  idx_q, idx_d;

   logic        dcol_q;
   logic        vid_q;
   logic [23:0] rgb_q, rgb_d;

   logic frame_tick, dcol_rise, apply;

   function automatic logic [23:0] palette(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = 24'hFF0000;
         3'd1:    c = 24'h00FF00;
         3'd2:    c = 24'h0000FF;
         3'd3:    c = 24'hFFFF00;
         3'd4:    c = 24'h00FFFF;
         3'd5:    c = 24'hFF00FF;
         3'd6:    c = 24'hFFFFFF;
         default: c = 24'h808080;
      endcase
      return c;
   endfunction

   function automatic logic [11:0] inc_clamp(input logic [11:0] v, input logic [11:0] lim);
      logic [12:0] s;
      s = {1'b0, v} + {1'b0, STEP_V};
      return (s > {1'b0, lim}) ? lim : s[11:0];
   endfunction

   function automatic logic [11:0] dec_clamp(input logic [11:0] v);
      return (v < STEP_V) ? 12'd0 : v - STEP_V;
   endfunction

   assign frame_tick = (line_cnt == 12'(V_ACTIVE)) && (pixel_cnt == 12'd0);
   assign dcol_rise  = dcolor & ~dcol_q;

   always_comb begin
      state_d = state_q;
      lsel_d  = lsel_q;
      lmv_d   = lmv_q;
      apply   = 1'b0;
      case (state_q)
         IDLE:   if (frame_tick) state_d = SAMPLE;
         SAMPLE: begin
            lsel_d  = sel_box;
            lmv_d   = {move_up, move_down, move_left, move_right};
            state_d = APPLY;
         end
         APPLY: begin
            apply   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Opposing requests cancel; orthogonal ones both apply.
   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      idx_d = idx_q;
      for (int i = 0; i < NUM_BOXES; i++) begin
         if (apply && lsel_q == 2'(i)) begin
            if (lmv_q[0] && !lmv_q[1])      x_d[i] = inc_clamp(x_q[i], X_MAX);
            else if (lmv_q[1] && !lmv_q[0]) x_d[i] = dec_clamp(x_q[i]);
            if (lmv_q[2] && !lmv_q[3])      y_d[i] = inc_clamp(y_q[i], Y_MAX);
            else if (lmv_q[3] && !lmv_q[2]) y_d[i] = dec_clamp(y_q[i]);
         end
         if (dcol_rise && sel_box == 2'(i)) idx_d[i] = idx_q[i] + 3'd1;
      end
   end

   // Scan from highest index down so the lowest-index hit ends up winning.
   always_comb begin
      rgb_d = BG_COLOR;
      for (int i = NUM_BOXES - 1; i >= 0; i--) begin
         if (({1'b0, pixel_cnt} >= {1'b0, x_q[i]}) &&
             ({1'b0, pixel_cnt} <= {1'b0, x_q[i]} + 13'(BOX_W - 1)) &&
             ({1'b0, line_cnt}  >= {1'b0, y_q[i]}) &&
             ({1'b0, line_cnt}  <= {1'b0, y_q[i]} + 13'(BOX_H - 1)))
            rgb_d = palette(idx_q[i]);
      end
   end

   always_ff @(posedge rfr_clk) begin
      if (reset) begin
         state_q <= IDLE;
         lsel_q  <= 2'd0;
         lmv_q   <= 4'd0;
         dcol_q  <= 1'b0;
         vid_q   <= 1'b0;
         rgb_q   <= 24'h0;
         for (int i = 0; i < NUM_BOXES; i++) begin
            x_q[i]   <= 12'(i * (BOX_W + 16));
            y_q[i]   <= 12'd0;
            idx_q[i] <= 3'(i);
         end
      end else begin
         state_q <= state_d;
         lsel_q  <= lsel_d;
         lmv_q   <= lmv_d;
         dcol_q  <= dcolor;
         vid_q   <= video_on;
         rgb_q   <= rgb_d;
         x_q     <= x_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
      end
   end

   assign {p_red, p_green, p_blue} = vid_q ? rgb_q : 24'h000000;

endmodule
